ntt_core_gf64_reduction_pipe: RTL and testbench

C-lane pipelined full modular reduction of signed (2s complement) OP_W-bit operands modulo the Goldilocks prime p = 2^64 - 2^32 + 1, for the GF64 NTT datapath between butterfly/twiddle stages and the next network stage.
Successor of the fixed single-mode lane reduction. It adds a configurable pipeline depth (input/mid/output registers) and a per-beat runtime mode: canonical output in [0,p) or lazy output in [0,2^64).
Data, mode and side data travel through the same pipeline with avail-qualified, no-backpressure flow.

---
 rtl/ntt_core_gf64_reduction_pipe.sv | 189 ++++++++++++++++++
 tb/tb_ntt_core_gf64_reduction_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core_gf64_reduction_pipe.sv
// rtl/ntt_core_gf64_reduction_pipe.sv - C-lane pipelined signed reduction modulo p = 2^64 - 2^32 + 1
// Two folds of the high part by 2^64 == 2^32 - 1 (mod p), one +/-p correction, optional canonical subtract.
module ntt_core_gf64_reduction_pipe #(
    parameter int         C         = 32,
    parameter int         MOD_NTT_W = 64,
    parameter int         OP_W      = 66,
    parameter int         IN_PIPE   = 1,
    parameter int         MID_PIPE  = 1,
    parameter int         OUT_PIPE  = 1,
    parameter int         SIDE_W    = 0,
    parameter logic [1:0] RST_SIDE  = 2'b00
) (
    input  logic                                   clk,
    input  logic                                   s_rst_n,
    input  logic [C*OP_W-1:0]                      in_data,
    input  logic [C-1:0]                           in_avail,
    input  logic                                   in_canon,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    output logic [C*64-1:0]                        out_data,
    output logic [C-1:0]                           out_avail,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);
    localparam int          SW  = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int          HW  = OP_W - 64;
    localparam logic [97:0] P98 = 98'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] P64 = 64'hFFFF_FFFF_0000_0001;

    if (MOD_NTT_W != 64 || OP_W < 65 || OP_W > 96) begin : g_bad_param
        $error("ntt_core_gf64_reduction_pipe: MOD_NTT_W must be 64 and OP_W must be 65..96");
    end

    logic                   mode_held;
    logic                   mode_in;
    logic [C-1:0][OP_W-1:0] s0_data;
    logic [C-1:0]           s0_av, s1_av, s2_av, s3_av;
    logic                   s0_mode, s1_mode;
    logic [SW-1:0]          s0_side, s1_side, s2_side, s3_side;
    logic [C-1:0][97:0]     t1_c, s1_t1;
    logic [C-1:0][63:0]     res_c, s2_res, s3_res;

    // Orphan beats (lane 0 idle) inherit the mode of the most recent lane-0 beat.
    assign mode_in = in_avail[0] ? in_canon : mode_held;

    always_ff @(posedge clk) begin
        if (!s_rst_n)
            mode_held <= 1'b1;
        else if (in_avail[0])
            mode_held <= in_canon;
    end

    if (IN_PIPE != 0) begin : g_in_reg
        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                s0_av   <= '0;
                s0_mode <= 1'b1;
            end else begin
                s0_av <= in_avail;
                if (|in_avail)
                    s0_mode <= mode_in;
            end
            if (!s_rst_n && RST_SIDE[0])
                s0_side <= '0;
            else if (!s_rst_n && RST_SIDE[1])
                s0_side <= '1;
            else if (in_avail[0])
                s0_side <= in_side;
            for (int i = 0; i < C; i++)
                if (in_avail[i])
                    s0_data[i] <= in_data[i*OP_W +: OP_W];
        end
    end else begin : g_in_wire
        assign s0_av   = in_avail;
        assign s0_mode = mode_in;
        assign s0_side = in_side;
        assign s0_data = in_data;
    end

    for (genvar i = 0; i < C; i++) begin : g_lane
        logic [97:0] hi_x, t1, hi2_x, t2, corr;
        logic [63:0] r;

        // All arithmetic is 98-bit two's complement; the sign lives in bit 97.
        always_comb begin
            hi_x  = {{(98-HW){s0_data[i][OP_W-1]}}, s0_data[i][OP_W-1:64]};
            t1    = {34'd0, s0_data[i][63:0]} + (hi_x << 32) - hi_x;
            hi2_x = {{64{s1_t1[i][97]}}, s1_t1[i][97:64]};
            t2    = {34'd0, s1_t1[i][63:0]} + (hi2_x << 32) - hi2_x;
            if (t2[97])
                corr = t2 + P98;
            else if (t2[97:64] != 34'd0)
                corr = t2 - P98;
            else
                corr = t2;
            r = corr[63:0];
        end

        assign t1_c[i]  = t1;
        assign res_c[i] = (s1_mode && (r >= P64)) ? (r - P64) : r;

        always_ff @(posedge clk) begin
            if (s_rst_n && s1_av[i])
                assert (corr[97:64] == 34'd0)
                else $error("lane %0d: corrected value outside [0, 2^64)", i);
        end
    end

    if (MID_PIPE != 0) begin : g_mid_reg
        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                s1_av   <= '0;
                s1_mode <= 1'b1;
            end else begin
                s1_av <= s0_av;
                if (|s0_av)
                    s1_mode <= s0_mode;
            end
            if (!s_rst_n && RST_SIDE[0])
                s1_side <= '0;
            else if (!s_rst_n && RST_SIDE[1])
                s1_side <= '1;
            else if (s0_av[0])
                s1_side <= s0_side;
            for (int i = 0; i < C; i++)
                if (s0_av[i])
                    s1_t1[i] <= t1_c[i];
        end
    end else begin : g_mid_wire
        assign s1_av   = s0_av;
        assign s1_mode = s0_mode;
        assign s1_side = s0_side;
        assign s1_t1   = t1_c;
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n)
            s2_av <= '0;
        else
            s2_av <= s1_av;
        if (!s_rst_n && RST_SIDE[0])
            s2_side <= '0;
        else if (!s_rst_n && RST_SIDE[1])
            s2_side <= '1;
        else if (s1_av[0])
            s2_side <= s1_side;
        for (int i = 0; i < C; i++)
            if (s1_av[i])
                s2_res[i] <= res_c[i];
    end

    if (OUT_PIPE != 0) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (!s_rst_n)
                s3_av <= '0;
            else
                s3_av <= s2_av;
            if (!s_rst_n && RST_SIDE[0])
                s3_side <= '0;
            else if (!s_rst_n && RST_SIDE[1])
                s3_side <= '1;
            else if (s2_av[0])
                s3_side <= s2_side;
            for (int i = 0; i < C; i++)
                if (s2_av[i])
                    s3_res[i] <= s2_res[i];
        end
    end else begin : g_out_wire
        assign s3_av   = s2_av;
        assign s3_side = s2_side;
        assign s3_res  = s2_res;
    end

    assign out_data  = s3_res;
    assign out_avail = s3_av;

    if (SIDE_W > 0) begin : g_side_out
        assign out_side = s3_side;
    end else begin : g_side_none
        logic unused_side;
        assign unused_side = ^s3_side;
        assign out_side    = '0;
    end

    // Orphan lanes pick up mode_held; flag it when an older beat in flight used another mode.
    always_ff @(posedge clk) begin
        if (s_rst_n && (|in_avail) && !in_avail[0])
            assert (!(((|s0_av) && (s0_mode != mode_held)) || ((|s1_av) && (s1_mode != mode_held))))
            else $warning("lanes issued without lane 0 while a mode change is in flight");
    end
endmodule

// File: tb/tb_ntt_core_gf64_reduction_pipe.sv
// tb/tb_ntt_core_gf64_reduction_pipe.sv - scoreboard bench for the GF64 reduction pipe
module tb_ntt_core_gf64_reduction_pipe;
    localparam int           C  = 4;
    localparam int           AW = 66;
    localparam int           BW = 96;
    localparam int           LA = 4;
    localparam int           LB = 2;
    localparam logic [127:0] P  = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001;

    typedef struct packed {
        logic [31:0]      due;
        logic [3:0]       mask;
        logic [3:0]       exact;
        logic [7:0]       side;
        logic [3:0][63:0] exp;
    } beat_t;

    logic            clk     = 1'b0;
    logic            s_rst_n = 1'b0;
    logic [C*AW-1:0] a_data  = '0;
    logic [C-1:0]    a_avail = '0;
    logic            a_canon = 1'b1;
    logic [7:0]      a_side  = '0;
    logic [C*64-1:0] a_out_data;
    logic [C-1:0]    a_out_avail;
    logic [7:0]      a_out_side;
    logic [C*BW-1:0] b_data  = '0;
    logic [C-1:0]    b_avail = '0;
    logic            b_canon = 1'b1;
    logic [C*64-1:0] b_out_data;
    logic [C-1:0]    b_out_avail;
    logic            unused_b_side;

    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    bit    mon_on = 1'b0;
    logic  a_held = 1'b1;
    logic  b_held = 1'b1;
    beat_t qa[$];
    beat_t qb[$];
    beat_t ba, bb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_core_gf64_reduction_pipe #(
        .C(C), .MOD_NTT_W(64), .OP_W(AW), .IN_PIPE(1), .MID_PIPE(1), .OUT_PIPE(1),
        .SIDE_W(8), .RST_SIDE(2'b01)
    ) dut_a (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(a_data), .in_avail(a_avail), .in_canon(a_canon),
        .in_side(a_side), .out_data(a_out_data), .out_avail(a_out_avail), .out_side(a_out_side)
    );

    ntt_core_gf64_reduction_pipe #(
        .C(C), .MOD_NTT_W(64), .OP_W(BW), .IN_PIPE(0), .MID_PIPE(0), .OUT_PIPE(1),
        .SIDE_W(0), .RST_SIDE(2'b00)
    ) dut_b (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(b_data), .in_avail(b_avail), .in_canon(b_canon),
        .in_side(1'b0), .out_data(b_out_data), .out_avail(b_out_avail), .out_side(unused_b_side)
    );

    // Reference: signed 128-bit operand reduced into [0, p).
    function automatic logic [63:0] modp(input logic [127:0] a);
        logic [127:0] m;
        if (a[127]) begin
            m = (~a + 128'd1) % P;
            m = (m == 128'd0) ? m : P - m;
        end else begin
            m = a % P;
        end
        return m[63:0];
    endfunction

    function automatic logic [127:0] rnd_op(input int w);
        logic [127:0] r;
        r = {32'd0, $urandom(), $urandom(), $urandom()};
        for (int k = w; k < 128; k++) r[k] = r[w-1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                              input logic exact);
        if (exact) check(tag, obs, exp);
        else       check({tag, "_congruent"}, modp({64'd0, obs}), exp);
    endtask

    // Lazy results are only pinned exactly when the operand already lies in [0, 2^64).
    task automatic make_beat(input logic [3:0][127:0] ops, input logic [3:0] mask, input logic eff,
                             input logic [7:0] side, input int lat, output beat_t b);
        b.due  = cyc + lat;
        b.mask = mask;
        b.side = side;
        for (int i = 0; i < C; i++) begin
            b.exact[i] = eff || (ops[i][127:64] == 64'd0);
            b.exp[i]   = (!eff && ops[i][127:64] == 64'd0) ? ops[i][63:0] : modp(ops[i]);
        end
    endtask

    task automatic drive_a(input logic [3:0] mask, input logic [3:0][127:0] ops, input logic canon,
                           input logic [7:0] side);
        beat_t b;
        logic  eff;
        eff = mask[0] ? canon : a_held;
        if (mask[0]) a_held = canon;
        make_beat(ops, mask, eff, side, LA, b);
        for (int i = 0; i < C; i++) a_data[i*AW +: AW] = ops[i][AW-1:0];
        a_avail = mask;
        a_canon = canon;
        a_side  = side;
        qa.push_back(b);
        @(negedge clk);
    endtask

    task automatic drive_b(input logic [3:0] mask, input logic [3:0][127:0] ops, input logic canon);
        beat_t b;
        logic  eff;
        eff = mask[0] ? canon : b_held;
        if (mask[0]) b_held = canon;
        make_beat(ops, mask, eff, 8'd0, LB, b);
        for (int i = 0; i < C; i++) b_data[i*BW +: BW] = ops[i][BW-1:0];
        b_avail = mask;
        b_canon = canon;
        qb.push_back(b);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        a_avail = '0;
        b_avail = '0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ba = qa.pop_front();
                check("a_avail", 64'(a_out_avail), 64'(ba.mask));
                for (int i = 0; i < C; i++)
                    if (ba.mask[i]) check_lane("a_data", a_out_data[i*64 +: 64], ba.exp[i], ba.exact[i]);
                if (ba.mask[0]) check("a_side", 64'(a_out_side), 64'(ba.side));
            end else begin
                check("a_idle_avail", 64'(a_out_avail), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                bb = qb.pop_front();
                check("b_avail", 64'(b_out_avail), 64'(bb.mask));
                for (int i = 0; i < C; i++)
                    if (bb.mask[i]) check_lane("b_data", b_out_data[i*64 +: 64], bb.exp[i], bb.exact[i]);
            end else begin
                check("b_idle_avail", 64'(b_out_avail), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][127:0] ops;
        ops = '0;
        repeat (3) @(negedge clk);
        check("rst_a_avail", 64'(a_out_avail), 64'd0);
        check("rst_b_avail", 64'(b_out_avail), 64'd0);
        check("rst_a_side", 64'(a_out_side), 64'd0);
        s_rst_n = 1'b1;
        mon_on  = 1'b1;

        ops[0] = 128'd0;
        ops[1] = P;
        ops[2] = P - 128'd1;
        ops[3] = '1;
        drive_a(4'hF, ops, 1'b1, 8'h11);
        idle(6);

        for (int i = 0; i < C; i++) ops[i] = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        drive_a(4'hF, ops, 1'b0, 8'h22);
        drive_a(4'hF, ops, 1'b1, 8'h23);
        idle(6);

        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < C; i++) ops[i] = rnd_op(AW);
            drive_a(4'hF, ops, 1'($urandom_range(0, 1)), 8'(k));
        end
        idle(6);

        ops = '0;
        for (int k = 0; k < 10; k++) begin
            ops[2] = rnd_op(AW);
            drive_a(4'b0100, ops, 1'b0, 8'h00);
            idle(2);
        end
        idle(6);

        ops[0] = 128'hFFFF_FFFF_8000_0000_0000_0000_0000_0000;
        ops[1] = 128'h0000_0000_7FFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        ops[2] = '1;
        ops[3] = P;
        drive_b(4'hF, ops, 1'b1);
        idle(4);
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < C; i++) ops[i] = rnd_op(BW);
            drive_b(4'hF, ops, (k >= 100));
        end
        idle(6);

        for (int i = 0; i < C; i++) ops[i] = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        drive_a(4'hF, ops, 1'b0, 8'h31);
        drive_a(4'hF, ops, 1'b0, 8'h32);
        drive_a(4'hF, ops, 1'b0, 8'h33);
        a_avail = '0;
        s_rst_n = 1'b0;
        qa.delete();
        a_held  = 1'b1;
        b_held  = 1'b1;
        @(negedge clk);
        s_rst_n = 1'b1;
        check("post_rst_avail", 64'(a_out_avail), 64'd0);
        check("post_rst_side", 64'(a_out_side), 64'd0);
        drive_a(4'b0100, ops, 1'b0, 8'h00);
        idle(8);

        for (int k = 0; k < 64 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
        check("queues_drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
